// File: rtl/bubble_sort_engine_if.sv
// Handshake/bus bundle between the bubble sort engine and its host/renderer.
// master drives the controls and writes; slave is the sort engine.
interface bubble_sort_engine_if #(
  parameter int N_BARS = 32,
  parameter int DATA_W = 8
);
  logic                     start;
  logic                     step_en;
  logic                     wr_en;
  logic [4:0]               wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [N_BARS*DATA_W-1:0] heights;
  logic [4:0]               cmp_idx;
  logic                     swapping;
  logic [1:0]               state;
  logic                     done;
  logic [4:0]               pass;
  logic [8:0]               swap_cnt;

  modport master (
    output start, step_en, wr_en, wr_addr, wr_data,
    input  heights, cmp_idx, swapping, state, done, pass, swap_cnt
  );

  modport slave (
    input  start, step_en, wr_en, wr_addr, wr_data,
    output heights, cmp_idx, swapping, state, done, pass, swap_cnt
  );
endinterface

// File: rtl/bubble_sort_engine.sv
// Paced bubble sort over a 32 x 8-bit bar-height array, one compare or swap per step_en.
// Optional macro BSORT_EARLY_EXIT_EN: end the sort after a pass that made no swaps.
module bubble_sort_engine #(
  parameter int N_BARS = 32,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  bubble_sort_engine_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_CMP     = 2'b01;
  localparam logic [1:0] S_SWAP    = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;
  localparam logic [4:0] LAST_PASS = 5'd30;
`ifdef BSORT_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [N_BARS];
  logic [1:0]        r_state;
  logic [4:0]        r_cmp_idx;
  logic [4:0]        r_pass;
  logic [8:0]        r_swap_cnt;
  logic              r_swapped;
  logic              r_start_q;
  logic              r_done;
  logic              r_swapping;

  logic              w_launch;
  logic [4:0]        w_idx_hi;
  logic [DATA_W-1:0] w_left;
  logic [DATA_W-1:0] w_right;
  logic              w_gt;
  logic              w_pass_end;
  logic              w_adv_swapped;
  logic              w_finish;
  logic [1:0]        w_adv_state;
  logic [4:0]        w_adv_idx;
  logic [4:0]        w_adv_pass;
  logic              w_adv_swapped_out;
  logic              w_adv_done;

  assign w_launch   = bus.start & ~r_start_q;
  assign w_idx_hi   = r_cmp_idx + 5'd1;
  assign w_left     = r_mem[r_cmp_idx];
  assign w_right    = r_mem[w_idx_hi];
  assign w_gt       = (w_left > w_right);
  assign w_pass_end = (r_cmp_idx == (LAST_PASS - r_pass));

  // ADVANCE step; a SWAP step counts as a swap in this pass before termination is judged.
  always_comb begin
    w_adv_swapped     = r_swapped;
    w_finish          = 1'b0;
    w_adv_state       = S_CMP;
    w_adv_idx         = w_idx_hi;
    w_adv_pass        = r_pass;
    w_adv_swapped_out = r_swapped;
    w_adv_done        = 1'b0;
    if (r_state == S_SWAP) begin
      w_adv_swapped = 1'b1;
    end else begin
      w_adv_swapped = r_swapped;
    end
    w_finish          = (r_pass == LAST_PASS) || (EARLY_EXIT && !w_adv_swapped);
    w_adv_swapped_out = w_adv_swapped;
    if (w_pass_end) begin
      if (w_finish) begin
        w_adv_state = S_DONE;
        w_adv_idx   = r_cmp_idx;
        w_adv_done  = 1'b1;
      end else begin
        w_adv_state       = S_CMP;
        w_adv_idx         = 5'd0;
        w_adv_pass        = r_pass + 5'd1;
        w_adv_swapped_out = 1'b0;
      end
    end else begin
      w_adv_state = S_CMP;
      w_adv_idx   = w_idx_hi;
    end
  end

  // Sort FSM and the height array it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BARS; i++) begin
        r_mem[i] <= DATA_W'(255 - 8 * i);
      end
      r_state    <= S_IDLE;
      r_cmp_idx  <= 5'd0;
      r_pass     <= 5'd0;
      r_swap_cnt <= 9'd0;
      r_swapped  <= 1'b0;
      r_start_q  <= 1'b0;
      r_done     <= 1'b0;
      r_swapping <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      case (r_state)
        S_IDLE: begin
          if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
          end
          if (w_launch) begin
            r_cmp_idx  <= 5'd0;
            r_pass     <= 5'd0;
            r_swap_cnt <= 9'd0;
            r_swapped  <= 1'b0;
            r_state    <= S_CMP;
          end
        end
        S_CMP: begin
          if (bus.step_en) begin
            if (w_gt) begin
              r_state    <= S_SWAP;
              r_swapping <= 1'b1;
            end else begin
              r_state   <= w_adv_state;
              r_cmp_idx <= w_adv_idx;
              r_pass    <= w_adv_pass;
              r_swapped <= w_adv_swapped_out;
              r_done    <= w_adv_done;
            end
          end
        end
        S_SWAP: begin
          if (bus.step_en) begin
            r_mem[r_cmp_idx] <= w_right;
            r_mem[w_idx_hi]  <= w_left;
            r_swap_cnt       <= r_swap_cnt + 9'd1;
            r_swapping       <= 1'b0;
            r_state          <= w_adv_state;
            r_cmp_idx        <= w_adv_idx;
            r_pass           <= w_adv_pass;
            r_swapped        <= w_adv_swapped_out;
            r_done           <= w_adv_done;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_swapping <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_BARS; g++) begin : g_heights
    assign bus.heights[g*DATA_W +: DATA_W] = r_mem[g];
  end

  assign bus.cmp_idx  = r_cmp_idx;
  assign bus.swapping = r_swapping;
  assign bus.state    = r_state;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.swap_cnt = r_swap_cnt;
endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed self-checking bench for bubble_sort_engine (both BSORT_EARLY_EXIT_EN builds).
module tb_bubble_sort_engine;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CMP  = 2'b01;
  localparam logic [1:0] S_SWAP = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;
`ifdef BSORT_EARLY_EXIT_EN
  localparam int SORTED_STEPS = 31;
`else
  localparam int SORTED_STEPS = 496;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   steps;
  logic [255:0] exp_h;

  always #5 clk = ~clk;

  bubble_sort_engine_if bus ();

  bubble_sort_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] desc_pattern();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(255 - 8 * i);
    return v;
  endfunction

  function automatic logic [255:0] asc_pattern(input int base, input int stride);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(base + stride * i);
    return v;
  endfunction

  task automatic start_sort();
    bus.start   = 1'b1;
    bus.step_en = 1'b1;
    @(negedge clk);
    check_val("launch_latency", bus.state, S_CMP);
  endtask

  task automatic run_sort(output int n);
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.done) break;
      if (bus.state == S_CMP || bus.state == S_SWAP) n++;
      @(negedge clk);
    end
    check_val("sort_done", bus.done, 1'b1);
  endtask

  task automatic go_idle();
    bus.start = 1'b0;
    @(negedge clk);
    check_val("idle_return", bus.state, S_IDLE);
  endtask

  task automatic write_entry(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = 8'(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.step_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_val("rst_state", bus.state, S_IDLE);
    check_val("rst_cmp_idx", bus.cmp_idx, 5'd0);
    check_val("rst_pass", bus.pass, 5'd0);
    check_val("rst_swap_cnt", bus.swap_cnt, 9'd0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_swapping", bus.swapping, 1'b0);
    check_val("rst_heights", bus.heights, desc_pattern());

    // Worst case: reverse-ordered default data.
    start_sort();
    run_sort(steps);
    check_val("rev_steps", 256'(steps), 256'd992);
    check_val("rev_swap_cnt", bus.swap_cnt, 9'd496);
    check_val("rev_heights", bus.heights, asc_pattern(7, 8));

    // DONE holds while start stays high; writes ignored there.
    write_entry(0, 0);
    repeat (2) @(negedge clk);
    check_val("done_hold", bus.state, S_DONE);
    check_val("done_no_write", bus.heights, asc_pattern(7, 8));
    go_idle();
    check_val("idle_done_low", bus.done, 1'b0);
    check_val("idle_kept", bus.heights, asc_pattern(7, 8));

    // Restart on already-sorted data.
    start_sort();
    check_val("restart_swap_cnt", bus.swap_cnt, 9'd0);
    run_sort(steps);
    check_val("presorted_steps", 256'(steps), 256'(SORTED_STEPS));
    check_val("presorted_swaps", bus.swap_cnt, 9'd0);
    go_idle();

    // Ascending 0..31 loaded by writes.
    for (int i = 0; i < 32; i++) write_entry(i, i);
    check_val("wr_asc", bus.heights, asc_pattern(0, 1));
    start_sort();
    run_sort(steps);
    check_val("asc_steps", 256'(steps), 256'(SORTED_STEPS));
    check_val("asc_swaps", bus.swap_cnt, 9'd0);
    check_val("asc_heights", bus.heights, asc_pattern(0, 1));
    go_idle();

    // All-equal values never swap.
    for (int i = 0; i < 32; i++) write_entry(i, 100);
    start_sort();
    run_sort(steps);
    check_val("eq_steps", 256'(steps), 256'(SORTED_STEPS));
    check_val("eq_swaps", bus.swap_cnt, 9'd0);
    check_val("eq_heights", bus.heights, asc_pattern(100, 0));
    go_idle();

    // Stall in SWAP after three steps from the default pattern.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_sort();
    repeat (3) @(negedge clk);
    bus.step_en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      bus.wr_en   = (c < 2);
      bus.wr_addr = 5'd3;
      bus.wr_data = 8'd0;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    exp_h = desc_pattern();
    exp_h[7:0]  = 8'd247;
    exp_h[15:8] = 8'd255;
    check_val("hold_state", bus.state, S_SWAP);
    check_val("hold_swapping", bus.swapping, 1'b1);
    check_val("hold_cmp_idx", bus.cmp_idx, 5'd1);
    check_val("hold_swap_cnt", bus.swap_cnt, 9'd1);
    check_val("hold_heights", bus.heights, exp_h);

    // Run to pass 5 then reset mid-sort.
    bus.step_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (bus.pass == 5'd5) break;
      @(negedge clk);
    end
    check_val("reach_pass5", bus.pass, 5'd5);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_state", bus.state, S_IDLE);
    check_val("mid_rst_pass", bus.pass, 5'd0);
    check_val("mid_rst_swap_cnt", bus.swap_cnt, 9'd0);
    check_val("mid_rst_entry0", bus.heights[7:0], 8'd255);
    check_val("mid_rst_entry31", bus.heights[255:248], 8'd7);
    @(negedge clk);
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.step_en = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

- Owns the 32-entry × 8-bit bar-height array and bubble-sorts it into ascending order, one compare or swap per pacing tick.
- It is the producer of the heights that the VGA bar renderer reads.
- Exports the array as a flat bus, plus the active compare index and swap flag so the renderer can highlight the moving pair.
- Also exports state, pass and swap count for the LEDs and SSD.

## Interface
Parameters:
- N_BARS, 32, number of array entries (fixed at 32; index width 5).
- DATA_W, 8, bits per entry.

Ports:
- clk  input  1  system clock; one clock, all state on its rising edge.
- reset  input  1  asynchronous, active-high; restores all state below immediately.
- start  input  1  level (switch); its rising edge launches a sort, low level returns DONE to IDLE.
- step_en  input  1  pacing strobe, one clk wide; each asserted cycle advances the FSM by one step.
- wr_en  input  1  array write strobe; honoured only in IDLE.
- wr_addr  input  5  write index.
- wr_data  input  8  write value.
- heights  output  256  entry i on bits [8i+7:8i].
- cmp_idx  output  5  left index of the pair under comparison (pair is cmp_idx, cmp_idx+1).
- swapping  output  1  high while in SWAP.
- state  output  2  IDLE=00, CMP=01, SWAP=10, DONE=11.
- done  output  1  high in DONE.
- pass  output  5  current pass number, 0..30.
- swap_cnt  output  9  swaps performed in the current sort.

## Operation
- Reset values:
  - entry i = 255 − 8i, i.e. 255, 247, …, 7.
  - state IDLE; cmp_idx 0; pass 0; swap_cnt 0; done 0; swapping 0.
  - internal swapped flag 0; start edge register 0.
- Start edge: start_q is start registered; the launch pulse is start & ~start_q.
- IDLE:
  - wr_en writes wr_data into entry wr_addr.
  - A launch pulse sets cmp_idx=0, pass=0, swap_cnt=0, swapped=0 and moves to CMP.
  - If wr_en and the launch pulse coincide, the write lands first and the sort starts on the next cycle.
- CMP, on step_en:
  - If entry[cmp_idx] > entry[cmp_idx+1], go to SWAP.
  - Otherwise perform ADVANCE.
  - Equal values never swap.
- SWAP, on step_en: exchange the pair, swap_cnt+1, swapped=1, then perform ADVANCE.
- ADVANCE:
  - If cmp_idx == 30 − pass, the pass is complete:
    - go to DONE if pass == 30, or if early exit is enabled and swapped == 0;
    - otherwise pass+1, cmp_idx=0, swapped=0, go to CMP.
  - Otherwise cmp_idx+1 and go to CMP.
- DONE: array is held and done=1; start low returns to IDLE with done=0 (array kept).
- Writes are ignored outside IDLE. A launch pulse is ignored outside IDLE.
- Arithmetic: unsigned 8-bit compare. swap_cnt never exceeds 496 (31·32/2), so no saturation logic.
- Reset mid-sort aborts immediately and reloads the default descending pattern.

## Timing
- Without step_en the FSM holds in CMP/SWAP indefinitely; outputs stay stable.
- Each compare costs one step_en; each swap costs one additional step_en.
- heights updates on the clk edge that completes a swap; cmp_idx, state and swapping update on the same edge as the transition.
- Latency, start rising edge to state=CMP: 1 clk.
- Latency, final ADVANCE to done=1: registered, same edge.
- Worst case (default reverse-ordered data): 496 compares + 496 swaps = 992 steps.
- Fully sorted input: 31 steps with early exit, 496 steps without.
- heights is a direct register output with no combinational path from inputs, so it is safe for the pixel-rate renderer.

## Configuration
- Macro BSORT_EARLY_EXIT_EN:
  - Defined: a pass with no swaps ends the sort (DONE) at the end of that pass.
  - Undefined: always runs all 31 passes; the swapped flag still exists but is not used for termination.

## Test plan
- Reset, then start 0→1, step_en every cycle → swap_cnt reaches 496, done=1 after 992 step cycles, heights ascending 7, 15, …, 255.
- Write entries to 0..31 ascending in IDLE, start, step_en every cycle:
  - with BSORT_EARLY_EXIT_EN → DONE after 31 steps, swap_cnt=0;
  - without it → DONE after 496 steps, swap_cnt=0.
- Load all 32 entries = 100, start → no swaps, sort terminates without swapping, and every entry stays 100.
- During CMP hold step_en low for 50 cycles → state, cmp_idx and heights unchanged; wr_en to addr 3 with data 0 → entry 3 unchanged.
- Assert reset mid-sort at pass 5 → immediately state=00, pass=0, swap_cnt=0, entry 0=255, entry 31=7.
- Start while in DONE with start held high → stays in DONE; drop start → IDLE next clk, array retained; raise start → new sort with swap_cnt=0.
